keyevent_ctrl: RTL

KEYEVENT_CTRL -- requirements
Module: keyevent_ctrl

---
 rtl/kb_defs.sv | 26 ++
 rtl/kb_event_fifo.sv | 71 +++++++
 rtl/keyevent_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/kb_defs.sv
// Shared scancode constants, prefix-decoder state encoding and event payload for the keyboard event controller.
package kb_defs;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned EVENT_W        = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kb_state_e;

   typedef struct packed {
      logic       shift;
      logic       capslock;
      logic [7:0] code;
   } kb_event_t;

endpackage

// File: rtl/kb_event_fifo.sv
// Event FIFO with a registered head word and valid flag; head reads 0 when empty.
module kb_event_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             valid,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = head_q;
   assign valid   = valid_q;

   // Next head: the entry behind the current head on a pop, or the write data when it lands in an empty slot.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (do_pop) begin
         if (count_q == CW'(1)) head_d = do_push ? wdata : '0;
         else                   head_d = mem_q[rd_ptr_q + AW'(1)];
      end else if (do_push && empty) begin
         head_d = wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         head_q  <= head_d;
         valid_q <= (count_d != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/keyevent_ctrl.sv
// PS/2 scancode prefix decoder with modifier tracking and an event FIFO.
// Optional typematic repeat filter enabled by KEYCTRL_REPEAT_FILTER_EN.
module keyevent_ctrl
   import kb_defs::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_scancode,
   input  logic       i_valid,
   input  logic       i_ready,
   output logic       o_valid,
   output logic [7:0] o_code,
   output logic       o_shift,
   output logic       o_capslock,
   output logic       o_capslock_led,
   output logic       o_overflow
);

   kb_state_e state_q, state_d;
   logic      shift_l_q, shift_l_d;
   logic      shift_r_q, shift_r_d;
   logic      caps_q, caps_d;
   logic      ovf_q, ovf_d;
   logic      push_req, pop;
   logic      fifo_full, fifo_empty, fifo_valid;
   kb_event_t push_ev, head_ev;
   logic [EVENT_W-1:0] fifo_rdata;
`ifdef KEYCTRL_REPEAT_FILTER_EN
   logic [7:0] last_make_q, last_make_d;
`endif

   assign pop     = i_ready && !fifo_empty;
   // Modifiers come from the registers, i.e. before the current byte updates them.
   assign push_ev = '{shift: shift_l_q | shift_r_q, capslock: caps_q, code: i_scancode};
   assign head_ev = kb_event_t'(fifo_rdata);

   always_comb begin
      state_d   = state_q;
      shift_l_d = shift_l_q;
      shift_r_d = shift_r_q;
      caps_d    = caps_q;
      push_req  = 1'b0;
`ifdef KEYCTRL_REPEAT_FILTER_EN
      last_make_d = last_make_q;
`endif
      if (i_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (i_scancode == SC_BREAK)       state_d   = ST_BRK;
               else if (i_scancode == SC_EXT)    state_d   = ST_EXT;
               else if (i_scancode == SC_LSHIFT) shift_l_d = 1'b1;
               else if (i_scancode == SC_RSHIFT) shift_r_d = 1'b1;
               else if (i_scancode == SC_CAPS) begin
`ifdef KEYCTRL_REPEAT_FILTER_EN
                  if (last_make_q != SC_CAPS) begin
                     caps_d      = !caps_q;
                     last_make_d = SC_CAPS;
                  end
`else
                  caps_d = !caps_q;
`endif
               end else begin
`ifdef KEYCTRL_REPEAT_FILTER_EN
                  if (last_make_q != i_scancode) begin
                     push_req    = 1'b1;
                     last_make_d = i_scancode;
                  end
`else
                  push_req = 1'b1;
`endif
               end
            end
            ST_BRK: begin
               if (i_scancode == SC_LSHIFT) shift_l_d = 1'b0;
               if (i_scancode == SC_RSHIFT) shift_r_d = 1'b0;
`ifdef KEYCTRL_REPEAT_FILTER_EN
               if (i_scancode == last_make_q) last_make_d = 8'h00;
`endif
               state_d = ST_IDLE;
            end
            ST_EXT: begin
               if (i_scancode == SC_BREAK)    state_d = ST_EXT_BRK;
               else if (i_scancode == SC_EXT) state_d = ST_EXT;
               else                           state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      ovf_d = ovf_q || (push_req && fifo_full && !pop);
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         shift_l_q <= 1'b0;
         shift_r_q <= 1'b0;
         caps_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_l_q <= shift_l_d;
         shift_r_q <= shift_r_d;
         caps_q    <= caps_d;
         ovf_q     <= ovf_d;
      end
   end

`ifdef KEYCTRL_REPEAT_FILTER_EN
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) last_make_q <= 8'h00;
      else          last_make_q <= last_make_d;
   end
`endif

   kb_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (i_rst_n),
      .push  (push_req),
      .pop   (pop),
      .wdata (push_ev),
      .rdata (fifo_rdata),
      .valid (fifo_valid),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign o_valid        = fifo_valid;
   assign o_code         = head_ev.code;
   assign o_shift        = head_ev.shift;
   assign o_capslock     = head_ev.capslock;
   assign o_capslock_led = caps_q;
   assign o_overflow     = ovf_q;

endmodule
